// File: rtl/core_alu_pipe.sv
// core_alu_pipe: input FIFO of {op, operand word} feeding a four-state
// load/execute/done pipeline with a registered result and zero/carry flags.
module core_alu_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_zero,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int H  = DATA_W / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + 3;

  typedef enum logic [1:0] {IDLE, LOAD, EXECUTE, DONE} state_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_MIN  = 3'b101,
    OP_MAX  = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     fifoMem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, rdPtr_q;
  logic [LW-1:0]     level_q;
  logic              fifoFull, fifoEmpty;
  logic              push, pop;
  logic [EW-1:0]     headEntry;
  logic [DATA_W-1:0] opA_q, opB_q;
  op_t               op_q;
  logic [H:0]        sumAdd;
  logic [DATA_W-1:0] result_d;
  logic              zero_d, carry_d;
  logic [DATA_W-1:0] outData_q;
  logic              outZero_q, outCarry_q;

  // The level counter alone decides full/empty, so pointers only need AW bits.
  assign fifoFull   = (level_q == LW'(DEPTH));
  assign fifoEmpty  = (level_q == '0);
  assign in_ready   = !fifoFull;
  assign push       = in_valid && !fifoFull;
  assign headEntry  = fifoMem_q[rdPtr_q];

  assign out_valid  = (state_q == DONE);
  assign out_data   = outData_q;
  assign out_zero   = outZero_q;
  assign out_carry  = outCarry_q;
  assign fifo_level = level_q;

  // Next-state logic; the only consumer of the FIFO is the LOAD state.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    if (!fifoEmpty) state_d = LOAD;
      LOAD: begin
        pop     = 1'b1;
        state_d = EXECUTE;
      end
      EXECUTE: state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FIFO storage is plain data, so it is written without reset.
  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= {in_op, in_data};
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Operand capture during LOAD, halves zero-extended to the full word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opA_q <= '0;
      opB_q <= '0;
      op_q  <= OP_AND;
    end else if (state_q == LOAD) begin
      opA_q <= {{(DATA_W-H){1'b0}}, headEntry[DATA_W-1:H]};
      opB_q <= {{(DATA_W-H){1'b0}}, headEntry[H-1:0]};
      op_q  <= op_t'(headEntry[EW-1:DATA_W]);
    end
  end

  // ALU: ADD keeps its carry as bit H of the result, SUB reports a borrow.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    sumAdd   = {1'b0, opA_q[H-1:0]} + {1'b0, opB_q[H-1:0]};
    case (op_q)
      OP_AND:  result_d = opA_q & opB_q;
      OP_OR:   result_d = opA_q | opB_q;
      OP_XOR:  result_d = opA_q ^ opB_q;
      OP_ADD: begin
        result_d = {{(DATA_W-H-1){1'b0}}, sumAdd};
        carry_d  = sumAdd[H];
      end
      OP_SUB: begin
        result_d = opA_q - opB_q;
        carry_d  = (opA_q < opB_q);
      end
      OP_MIN:  result_d = (opA_q < opB_q) ? opA_q : opB_q;
      OP_MAX:  result_d = (opA_q < opB_q) ? opB_q : opA_q;
      OP_PASS: result_d = opA_q;
    endcase
    zero_d = (result_d == '0);
  end

  // Result registers load only in EXECUTE, so they hold steady through DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outData_q  <= '0;
      outZero_q  <= 1'b0;
      outCarry_q <= 1'b0;
    end else if (state_q == EXECUTE) begin
      outData_q  <= result_d;
      outZero_q  <= zero_d;
      outCarry_q <= carry_d;
    end
  end

endmodule

// File: doc/core_alu_pipe.md
CORE_ALU_PIPE -- requirements
Module: core_alu_pipe

Interface
REQ-001 Parameter DATA_W, default 32, sets the word width; it SHALL be even and at least 8, and H = DATA_W/2.
REQ-002 Parameter DEPTH, default 4, sets the input FIFO entry count; it SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers in_data/in_op.
REQ-006 in_ready  output  1  block can accept a word; SHALL equal !fifo_full.
REQ-007 in_data  input  DATA_W  operand word: operand a = in_data[DATA_W-1:H], operand b = in_data[H-1:0].
REQ-008 in_op  input  3  operation select, captured with in_data.
REQ-009 out_valid  output  1  result available; SHALL be high exactly while the FSM is in DONE.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  DATA_W  registered result.
REQ-012 out_zero  output  1  registered flag: out_data == 0.
REQ-013 out_carry  output  1  registered flag: ADD carry out of bit H-1, or SUB borrow (a < b); 0 for all other ops.
REQ-014 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Push SHALL occur when in_valid && in_ready, storing {in_op, in_data} at the write pointer.
REQ-016 Pointers SHALL wrap modulo DEPTH; the full/empty decision SHALL use an extra pointer bit or the level count.
REQ-017 Push and pop in the same cycle SHALL leave fifo_level unchanged.
REQ-018 When full, in_ready SHALL be 0 and in_valid SHALL have no effect.
REQ-019 FSM states SHALL be IDLE, LOAD, EXECUTE, DONE.
REQ-020 IDLE -> LOAD when the FIFO is non-empty; otherwise the FSM stays in IDLE.
REQ-021 LOAD -> EXECUTE unconditionally; in LOAD the FSM SHALL pop one entry and register a, b (zero-extended to DATA_W) and op.
REQ-022 EXECUTE -> DONE unconditionally; in EXECUTE the FSM SHALL register out_data, out_zero and out_carry.
REQ-023 DONE -> IDLE when out_ready = 1; otherwise the FSM stays in DONE, with out_data and the flags held stable.
REQ-024 Operations: 000 AND, 001 OR, 010 XOR, 011 ADD (a+b, result width H+1), 100 SUB (a-b modulo 2^DATA_W), 101 MIN (unsigned), 110 MAX (unsigned), 111 PASS a.
REQ-025 Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE SHALL produce out_valid = 1 after edge N+3.
REQ-026 Maximum throughput SHALL be one result per 4 cycles with out_ready tied high.
REQ-027 Results SHALL leave in FIFO order; no entry SHALL be dropped or duplicated.
REQ-028 A push while the FSM is in DONE and out_ready = 0 SHALL be accepted if the FIFO is not full.

Reset
REQ-029 reset_n low SHALL asynchronously force the FSM to IDLE, empty the FIFO (fifo_level = 0, pointers = 0), and clear out_data, out_zero, out_carry and out_valid to 0.
REQ-030 in_ready SHALL be 1 during and after reset.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries and any pending result; no out_valid pulse SHALL follow the release of reset.

Verification
REQ-032 DATA_W=32, push 0xFF0F_0F0F with op AND, out_ready high -> out_valid after edge N+3, out_data = 0x0000_0F0F, out_zero = 0.
REQ-033 Push 0xFFFF_0001 with op ADD -> out_data = 0x0001_0000, out_carry = 1; push 0x0001_0002 with op SUB -> out_data = 0xFFFF_FFFF, out_carry = 1.
REQ-034 out_ready low; push DEPTH+1 words -> in_ready drops after DEPTH pushes, fifo_level = DEPTH, out_data stable; release out_ready -> all results drain in order.
REQ-035 Push 0x1234_1234 with op XOR -> out_data = 0, out_zero = 1; MIN/MAX on 0x0005_0003 -> 3 and 5 respectively.
REQ-036 Assert reset_n while in EXECUTE with 2 entries queued -> immediate IDLE, fifo_level = 0, out_valid = 0, and no output after release.
REQ-037 Run with DATA_W=16, DEPTH=2 and 200 random pushes against random out_ready -> scoreboard match, with no overflow or underflow.
